// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall, branch flush.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module pipeline_hazard_unit #(
  parameter int NREAD   = 2,
  parameter int REGBITS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic                       issue_we,
  input  logic [REGBITS-1:0]         issue_wa,
  input  logic                       issue_load,
  input  logic [NREAD*REGBITS-1:0]   issue_ra,
  input  logic [NREAD-1:0]           issue_ruse,
  input  logic                       branch_taken,
  output logic [2*NREAD-1:0]         fwd_sel,
  output logic                       stall_f,
  output logic                       stall_d,
  output logic                       flush_d,
  output logic                       flush_e,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                flush_cnt
);

  // The all-ones index is the PC and never carries a register hazard.
  localparam logic [REGBITS-1:0] PC_IDX = '1;

  // Execute-stage tag slot
  logic                      vld_p0;
  logic                      we_p0;
  logic [REGBITS-1:0]        wa_p0;
  logic                      load_p0;
  logic [NREAD*REGBITS-1:0]  ra_p0;
  logic [NREAD-1:0]          ruse_p0;

  // Memory-stage tag slot
  logic                      vld_p1;
  logic                      we_p1;
  logic [REGBITS-1:0]        wa_p1;

  // Writeback-stage tag slot
  logic                      vld_p2;
  logic                      we_p2;
  logic [REGBITS-1:0]        wa_p2;

  logic                      lu_hit;
  logic                      load_use;
  logic                      take_e;

  function automatic logic src_match(input logic             vld,
                                     input logic             we,
                                     input logic [REGBITS-1:0] wa,
                                     input logic [REGBITS-1:0] ra,
                                     input logic             used);
    return vld && we && used && (wa == ra) && (ra != PC_IDX);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Decode-stage load-use detection against the load sitting in E
  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      if (src_match(1'b1, 1'b1, wa_p0, issue_ra[k*REGBITS +: REGBITS], issue_ruse[k]))
        lu_hit = 1'b1;
    end
  end

  assign load_use = vld_p0 && load_p0 && we_p0 && issue_valid && lu_hit;

  // Branch redirect wins over the load-use stall; both squash the E slot.
  assign stall_f = load_use && !branch_taken;
  assign stall_d = load_use && !branch_taken;
  assign flush_d = branch_taken;
  assign flush_e = load_use || branch_taken;

  assign take_e  = issue_valid && !flush_e && !stall_d;

  // Execute-stage operand forwarding; M has priority over W
  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (vld_p0) begin
        if (src_match(vld_p1, we_p1, wa_p1, ra_p0[k*REGBITS +: REGBITS], ruse_p0[k]))
          fwd_sel[2*k +: 2] = 2'b01;
        else if (src_match(vld_p2, we_p2, wa_p2, ra_p0[k*REGBITS +: REGBITS], ruse_p0[k]))
          fwd_sel[2*k +: 2] = 2'b10;
      end
    end
  end

  // Tag pipeline control: D -> E -> M -> W
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= take_e;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Tag pipeline fields; meaningful only where the matching valid is set
  always_ff @(posedge clk) begin
    we_p0   <= issue_we;
    wa_p0   <= issue_wa;
    load_p0 <= issue_load;
    ra_p0   <= issue_ra;
    ruse_p0 <= issue_ruse;
    we_p1   <= we_p0;
    wa_p1   <= wa_p0;
    we_p2   <= we_p1;
    wa_p2   <= wa_p1;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_d)
        stall_cnt <= sat_inc(stall_cnt);
      if (branch_taken)
        flush_cnt <= sat_inc(flush_cnt);
    end
  end
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: directed hazard scenarios plus randomized traffic
// checked against a slot-level reference model of the E/M/W tag pipeline.
module tb_pipeline_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_we = 1'b0;
  logic [3:0]  issue_wa = 4'd0;
  logic        issue_load = 1'b0;
  logic [7:0]  issue_ra = 8'd0;
  logic [1:0]  issue_ruse = 2'd0;
  logic        branch_taken = 1'b0;
  logic [3:0]  fwd_sel;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt, flush_cnt;

  int tests = 0;
  int failed = 0;

  pipeline_hazard_unit #(.NREAD(2), .REGBITS(4)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_wa(issue_wa), .issue_load(issue_load), .issue_ra(issue_ra),
    .issue_ruse(issue_ruse), .branch_taken(branch_taken), .fwd_sel(fwd_sel),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one record per instruction slot, index 0 = E, 1 = M, 2 = W
  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [3:0] wa;
    logic [7:0] ra;
    logic [1:0] ruse;
  } slot_t;

  typedef struct packed {
    logic [3:0]  fwd;
    logic [3:0]  ctl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  slot_t pipe [3];
  exp_t  exp_q [$];
  int    m_scnt = 0;
  int    m_fcnt = 0;
  logic  m_stall, m_flush_d, m_flush_e;
  logic [3:0] m_fwd;

  function automatic logic writes(input slot_t s, input logic [3:0] r);
    return s.v && s.we && s.wa == r;
  endfunction

  task automatic model_eval();
    logic hit;
    logic [3:0] r;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r = issue_ra[k*4 +: 4];
      if (issue_ruse[k] && r != 4'hF && r == pipe[0].wa) hit = 1'b1;
    end
    hit = hit && pipe[0].v && pipe[0].ld && pipe[0].we && issue_valid;
    m_stall   = hit && !branch_taken;
    m_flush_d = branch_taken;
    m_flush_e = hit || branch_taken;
    m_fwd = 4'd0;
    for (int k = 0; k < 2; k++) begin
      r = pipe[0].ra[k*4 +: 4];
      if (pipe[0].v && pipe[0].ruse[k] && r != 4'hF) begin
        if (writes(pipe[1], r))      m_fwd[k*2 +: 2] = 2'b01;
        else if (writes(pipe[2], r)) m_fwd[k*2 +: 2] = 2'b10;
      end
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      m_scnt = 0;
      m_fcnt = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (m_stall && m_scnt < 65535) m_scnt++;
      if (branch_taken && m_fcnt < 65535) m_fcnt++;
`endif
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{v: issue_valid && !m_flush_e && !m_stall, we: issue_we, ld: issue_load,
                  wa: issue_wa, ra: issue_ra, ruse: issue_ruse};
    end
  endtask

  // Drive one decode cycle and queue the response the model predicts for it
  task automatic step(input logic v, input logic we, input logic [3:0] wa, input logic ld,
                      input logic [7:0] ra, input logic [1:0] ruse, input logic b, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    issue_valid = v; issue_we = we; issue_wa = wa; issue_load = ld;
    issue_ra = ra; issue_ruse = ruse; branch_taken = b; reset = r;
    model_eval();
    e.fwd = m_fwd;
    e.ctl = {m_stall, m_stall, m_flush_d, m_flush_e};
    e.sc  = 16'(m_scnt);
    e.fc  = 16'(m_fcnt);
    exp_q.push_back(e);
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chk_now(input string name, input logic [3:0] fwd_want, input logic [3:0] ctl_want);
    @(negedge clk);
    chk({name, "_fwd"}, {12'd0, fwd_sel}, {12'd0, fwd_want});
    chk({name, "_ctl"}, {12'd0, stall_f, stall_d, flush_d, flush_e}, {12'd0, ctl_want});
  endtask

  // Monitor: every cycle the DUT presents a response, compare it to the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_fwd_sel", {12'd0, fwd_sel}, {12'd0, e.fwd});
        chk("sb_ctl", {12'd0, stall_f, stall_d, flush_d, flush_e}, {12'd0, e.ctl});
        chk("sb_stall_cnt", stall_cnt, e.sc);
        chk("sb_flush_cnt", flush_cnt, e.fc);
      end
    end
  end

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    m_stall = 1'b0; m_flush_d = 1'b0; m_flush_e = 1'b0; m_fwd = 4'd0;

    // Reset with garbage on the inputs, then one idle cycle
    step(1'b1, 1'b1, 4'd1, 1'b1, 8'h11, 2'b11, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd1, 1'b1, 8'h11, 2'b11, 1'b0, 1'b1);
    bubble();
    chk_now("reset", 4'b0000, 4'b0000);
    chk("reset_stall_cnt", stall_cnt, 16'd0);
    chk("reset_flush_cnt", flush_cnt, 16'd0);

    // ALU chain: ADD R1; SUB reads R1 (M forward); OR reads R1 (W forward)
    step(1'b1, 1'b1, 4'd1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd4, 1'b0, 8'h01, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd5, 1'b0, 8'h01, 2'b01, 1'b0, 1'b0);
    chk_now("alu_fwd_m", 4'b0001, 4'b0000);
    bubble();
    chk_now("alu_fwd_w", 4'b0010, 4'b0000);
    bubble(); bubble();

    // Load-use: LDR R2; ADD reads R2 on port 1 -> single stall, then W forward
    step(1'b1, 1'b1, 4'd2, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd6, 1'b0, 8'h20, 2'b10, 1'b0, 1'b0);
    chk_now("lu_stall", 4'b0000, 4'b1101);
    step(1'b1, 1'b1, 4'd6, 1'b0, 8'h20, 2'b10, 1'b0, 1'b0);
    chk_now("lu_release", 4'b0000, 4'b0000);
    bubble();
    chk_now("lu_fwd_w", 4'b1000, 4'b0000);
    bubble(); bubble();

    // Priority: two writers of R3, reader of R3 sees M
    step(1'b1, 1'b1, 4'd3, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd3, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd7, 1'b0, 8'h03, 2'b01, 1'b0, 1'b0);
    bubble();
    chk_now("prio_m_over_w", 4'b0001, 4'b0000);
    bubble(); bubble();

    // R15: load to PC, consumer reads PC on both ports -> no stall, no forward
    step(1'b1, 1'b1, 4'hF, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd8, 1'b0, 8'hFF, 2'b11, 1'b0, 1'b0);
    chk_now("r15_no_stall", 4'b0000, 4'b0000);
    bubble();
    chk_now("r15_no_fwd", 4'b0000, 4'b0000);
    bubble(); bubble();

    // Branch vs load-use in the same cycle: flush wins, no stall
    step(1'b1, 1'b1, 4'd2, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd6, 1'b0, 8'h20, 2'b10, 1'b1, 1'b0);
    chk_now("br_over_stall", 4'b0000, 4'b0011);
    bubble(); bubble();

    // Reset asserted during a load-use cycle
    step(1'b1, 1'b1, 4'd2, 1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd6, 1'b0, 8'h20, 2'b10, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'd6, 1'b0, 8'h20, 2'b10, 1'b0, 1'b0);
    chk_now("rst_mid_stall", 4'b0000, 4'b0000);
    chk("rst_mid_stall_scnt", stall_cnt, 16'd0);
    chk("rst_mid_stall_fcnt", flush_cnt, 16'd0);

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, rand_reg(),
           $urandom_range(0, 2) == 0, {rand_reg(), rand_reg()}, 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 2);
    end
    bubble();

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 SHALL provide parameter NREAD, default 2, number of decode-stage source register ports.
REQ-002 SHALL provide parameter REGBITS, default 4, register-index width; index all-ones (R15/PC) is never a hazard source.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port issue_valid  input  1  decode stage holds a valid instruction.
REQ-006 SHALL provide port issue_we  input  1  decode instruction writes a register.
REQ-007 SHALL provide port issue_wa  input  REGBITS  decode destination index.
REQ-008 SHALL provide port issue_load  input  1  decode instruction is a memory load.
REQ-009 SHALL provide port issue_ra  input  NREAD*REGBITS  decode source indices; port k occupies bits [k*REGBITS +: REGBITS].
REQ-010 SHALL provide port issue_ruse  input  NREAD  per-port source-used flags.
REQ-011 SHALL provide port branch_taken  input  1  execute-stage redirect (PCSrc) asserted.
REQ-012 SHALL provide port fwd_sel  output  2*NREAD  per execute operand: 00 regfile, 01 ALUOutM, 10 Result (W); 11 never driven.
REQ-013 SHALL provide ports stall_f, stall_d, flush_d, flush_e  output  1 each.
REQ-014 SHALL provide ports stall_cnt, flush_cnt  output  16 each  performance counters (see Configuration).

Function
REQ-015 SHALL hold an internal tag pipeline of three slots E, M, W; each holds valid, we, wa, load, plus E holds ra[NREAD] and ruse[NREAD].
REQ-016 SHALL advance every cycle: W<=M, M<=E, E<=decode fields, or a bubble (valid=0) when issue_valid=0, flush_e=1, or stall_d=1.
REQ-017 SHALL compute fwd_sel port k combinationally from registered E/M/W: 01 if M.valid & M.we & M.wa==E.ra[k] & E.ruse[k] & E.ra[k]!=all-ones; else 10 if same test matches W; else 00.
REQ-018 SHALL give M priority over W when both match the same operand.
REQ-019 SHALL assert load-use stall when E.valid & E.load & E.we and any used decode port k has issue_ra[k]==E.wa and issue_ra[k]!=all-ones: stall_f=stall_d=flush_e=1 for that cycle.
REQ-020 SHALL limit load-use stall to exactly one cycle per load; next cycle the load is in M and the consumer forwards from W.
REQ-021 SHALL on branch_taken=1 assert flush_d=flush_e=1 in the same cycle and insert a bubble into E.
REQ-022 SHALL give branch_taken priority over load-use: stall_f=stall_d=0 when both conditions hold.
REQ-023 SHALL not stall or flush when issue_valid=0, except flush_e/flush_d driven by branch_taken.
REQ-024 SHALL treat a destination of all-ones as non-forwardable in every comparison.

Reset
REQ-025 SHALL on reset=1 at a rising edge clear valid in E, M, W and zero all counters.
REQ-026 SHALL drive fwd_sel=0, stall_f=stall_d=flush_d=flush_e=0 in the cycle after reset, regardless of inputs, except flush_d/flush_e may follow branch_taken.
REQ-027 SHALL let reset override any in-progress stall; no stall persists past reset.

Configuration
REQ-028 SHALL compile performance counters only when macro HAZARD_PERF_EN is defined.
REQ-029 SHALL with HAZARD_PERF_EN increment stall_cnt on each cycle stall_d=1 and flush_cnt on each cycle branch_taken=1, both saturating at 16'hFFFF.
REQ-030 SHALL without HAZARD_PERF_EN keep both ports present and drive them constant 0, with no counter flops.

Verification
REQ-031 SHALL cover ALU chain: ADD R1 issued, next cycle SUB using R1 on port 0 -> when SUB in E, fwd_sel[1:0]=01; one cycle later, independent consumer of R1 in E sees 10.
REQ-032 SHALL cover load-use: LDR R2 then ADD reading R2 on port 1 -> exactly one cycle stall_f=stall_d=flush_e=1, then fwd_sel[3:2]=10 when ADD in E.
REQ-033 SHALL cover priority: M and W both writing R3, E reads R3 -> fwd_sel=01.
REQ-034 SHALL cover R15: writer and reader both index 4'hF -> fwd_sel=00, no stall.
REQ-035 SHALL cover branch vs stall: load-use condition and branch_taken=1 same cycle -> flush_d=flush_e=1, stall_f=stall_d=0; with HAZARD_PERF_EN flush_cnt+1, stall_cnt unchanged.
REQ-036 SHALL cover reset mid-stall: reset=1 during load-use cycle -> next cycle all outputs 0, counters 0.
